inst_loader: RTL
================

// Module: inst_loader
// PURPOSE
//   Writer side of the instruction-memory port. At boot the processor core only reads inst_memory
//   (its write port is tied off). This block drives that write port.
//   It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
//   It writes the words to consecutive word addresses, then releases the core via cpu_hold.
//   Stream format: 4-byte word count N, then N 4-byte instruction words.
// PARAMETERS
//   MEM_DEPTH  1024  instruction memory depth in words; a header N > MEM_DEPTH is an error
//   BASE_ADDR  0     word address of the first instruction written (core PC resets to 0)
// PORTS
//   clk                  in   1   system clock, all state on posedge
//   rst                  in   1   asynchronous, active-low reset (0 = reset)
//   start                in   1   single-cycle pulse; begins a load (see BEHAVIOUR)
//   in_valid             in   1   in_data holds a byte
//   in_data              in   8   stream byte
//   in_ready             out  1   loader can take a byte this cycle
//   inst_write_enable    out  1   one-cycle write strobe to inst_memory
//   inst_write_address   out  32  word address of the write
//   inst_data_in         out  32  instruction word written
//   cpu_hold             out  1   1 = core must be held in reset; tie to core rst OR'ed
//   done                 out  1   load finished; level, held until next start
//   error                out  1   header N exceeded MEM_DEPTH; level, held until next start
//   words_loaded         out  32  words written so far in the current load
// BEHAVIOUR
//   States: IDLE, LEN, DATA, WRITE, DONE, ERR. A byte transfers when in_valid && in_ready.
//   Reset (rst=0, async): state=IDLE, byte_cnt=0, index=0, N=0, cpu_hold=1.
//     All other outputs 0: in_ready, inst_write_enable, inst_write_address, inst_data_in,
//     done, error, words_loaded.
//   in_ready = 1 only in LEN and DATA; 0 in IDLE, WRITE, DONE, ERR.
//     A byte offered while in_ready=0 is not consumed.
//   Word assembly: the first byte of each group lands in [31:24], the 4th in [7:0].
//     byte_cnt is 2 bits and wraps 3->0 on the 4th byte.
//   IDLE: start -> LEN. cpu_hold stays 1.
//   LEN: on the 4th byte, N latches the assembled word. The next state is chosen on that edge:
//     N==0 -> DONE; N > MEM_DEPTH -> ERR; otherwise DATA with index=0.
//   DATA: on the 4th byte -> WRITE. inst_data_in and inst_write_address (BASE_ADDR+index)
//     register on the same edge.
//   WRITE: exactly one cycle with inst_write_enable=1. On exit, index and words_loaded
//     increment; index==N -> DONE, else DATA.
//   Latency: 4th data byte accepted at edge t. Strobe is high for the cycle after t.
//     in_ready returns high one cycle later.
//   Minimum cost is 5 cycles per word.
//   DONE: done=1, cpu_hold=0. ERR: error=1, cpu_hold=1; no write is ever issued after ERR entry.
//   start is ignored in LEN, DATA and WRITE.
//   start in DONE or ERR -> LEN on the next edge, and on that edge:
//     - done, error, index, words_loaded and byte_cnt clear;
//     - cpu_hold=1.
//   Address arithmetic is 32-bit unsigned. N <= MEM_DEPTH guarantees that the last address is
//     BASE_ADDR+N-1 and that the address never wraps.
//   Reset mid-load: state returns to IDLE immediately. inst_write_enable drops asynchronously.
//     Words already written are not undone; a new load overwrites them.
//   inst_data_in and inst_write_address hold their last values outside WRITE.
// TESTING
//   1 Assert rst=0 mid-cycle -> every output at its reset value at once.
//     cpu_hold=1, in_ready=0.
//   2 start; stream 00 00 00 02, 20 08 00 05, 01 09 50 20 -> two strobes:
//     addr 0 = 0x20080005, addr 1 = 0x01095020.
//     Then done=1, cpu_hold=0, words_loaded=2.
//   3 start; stream 00 00 00 00 -> DONE right after the 4th byte.
//     No write strobe; words_loaded=0, cpu_hold=0.
//   4 start; header = MEM_DEPTH+1 (0x00000401) -> error=1, in_ready=0, cpu_hold=1.
//     Later bytes are never consumed and no strobe is issued.
//   5 In DATA, drop in_valid between bytes and hold in_valid=1 through the WRITE cycle.
//     Required: no byte lost or duplicated, and the next word is assembled correctly.
//   6 Assert rst=0 after word 1 of 3 has been written, then release rst and pulse start.
//     Required: the loader restarts in LEN, writes from addr 0 again, and ends in DONE.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface inst_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        inst_write_enable;
  logic [31:0] inst_write_address;
  logic [31:0] inst_data_in;

  modport slave (
    input  in_valid, in_data,
    output in_ready, inst_write_enable, inst_write_address, inst_data_in
  );
  modport master (
    output in_valid, in_data,
    input  in_ready, inst_write_enable, inst_write_address, inst_data_in
  );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction loader: big-endian byte stream (count N, then N words) written to
// consecutive instruction-memory words; holds the core in reset until the load completes.
module inst_loader #(
  parameter int MEM_DEPTH = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  inst_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error,
  output logic [31:0]  words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] n_q, n_d;
  logic [31:0] index_q, index_d;
  logic [31:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        xfer;
  logic [31:0] word;

  // Status outputs decode state directly so reset takes effect without waiting for an edge.
  assign bus.in_ready           = (state_q == LEN) || (state_q == DATA);
  assign bus.inst_write_enable  = (state_q == WRITE);
  assign bus.inst_write_address = addr_q;
  assign bus.inst_data_in       = data_q;
  assign done                   = (state_q == DONE);
  assign error                  = (state_q == ERR);
  assign cpu_hold               = (state_q != DONE);
  assign words_loaded           = words_q;

  assign xfer = bus.in_valid && bus.in_ready;
  assign word = {asm_q, bus.in_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    n_d        = n_q;
    index_d    = index_q;
    words_d    = words_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LEN;
          byte_cnt_d = 2'd0;
        end
      end
      LEN: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = word[23:0];
          if (byte_cnt_q == 2'd3) begin
            n_d = word;
            if (word == 32'd0)                  state_d = DONE;
            else if (word > 32'(MEM_DEPTH))     state_d = ERR;
            else begin
              state_d = DATA;
              index_d = 32'd0;
            end
          end
        end
      end
      DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = word[23:0];
          if (byte_cnt_q == 2'd3) begin
            data_d  = word;
            addr_d  = 32'(BASE_ADDR) + index_q;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        index_d = index_q + 32'd1;
        words_d = words_q + 32'd1;
        state_d = (index_q + 32'd1 == n_q) ? DONE : DATA;
      end
      DONE, ERR: begin
        if (start) begin
          state_d    = LEN;
          index_d    = 32'd0;
          words_d    = 32'd0;
          byte_cnt_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      n_q        <= 32'd0;
      index_q    <= 32'd0;
      words_q    <= 32'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      index_q    <= index_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end
endmodule
